// File: rtl/instr_encoder_writer_if.sv
`default_nettype none
// ============================================================================
// Module      : instr_encoder_writer_if
// Description : Decoded-instruction request channel (valid/ready) carrying
//               class, register indices, funct fields and immediate.
// Revision    : 1.0 - initial release
// ============================================================================
interface instr_encoder_writer_if;
  logic        req_valid;
  logic        req_ready;
  logic [4:0]  req_class;
  logic [4:0]  req_rd;
  logic [4:0]  req_rs1;
  logic [4:0]  req_rs2;
  logic [2:0]  req_funct3;
  logic [6:0]  req_funct7;
  logic [31:0] req_imm;

  // Request producer (loader / self-test)
  modport master (
    output req_valid, req_class, req_rd, req_rs1, req_rs2,
           req_funct3, req_funct7, req_imm,
    input  req_ready
  );

  // Request consumer (the encoder)
  modport slave (
    input  req_valid, req_class, req_rd, req_rs1, req_rs2,
           req_funct3, req_funct7, req_imm,
    output req_ready
  );
endinterface
`default_nettype wire

// File: rtl/instr_encoder_writer.sv
`default_nettype none
// ============================================================================
// Module      : instr_encoder_writer
// Description : Packs decoded instruction requests into RV32I words, buffers
//               them in a small FIFO and streams them into IMEM at
//               consecutive word addresses.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_encoder_writer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32
) (
  input  wire logic                     clk,
  input  wire logic                     rst_n,
  input  wire logic                     start,
  input  wire logic [ADDR_W-1:0]        base_addr,
  instr_encoder_writer_if.slave         req,
  output logic                          mem_wr_en,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic [31:0]                   mem_wr_data,
  input  wire logic                     mem_wr_ready,
  output logic [$clog2(DEPTH):0]        count,
  output logic                          illegal
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [4:0] c_cls_load   = 5'h00;
  localparam logic [4:0] c_cls_fence  = 5'h03;
  localparam logic [4:0] c_cls_op_imm = 5'h04;
  localparam logic [4:0] c_cls_auipc  = 5'h05;
  localparam logic [4:0] c_cls_store  = 5'h08;
  localparam logic [4:0] c_cls_op     = 5'h0C;
  localparam logic [4:0] c_cls_lui    = 5'h0D;
  localparam logic [4:0] c_cls_branch = 5'h18;
  localparam logic [4:0] c_cls_jalr   = 5'h19;
  localparam logic [4:0] c_cls_jal    = 5'h1B;

  localparam logic [CNT_W-1:0] c_full = CNT_W'(DEPTH);

  logic [31:0]       fifo_q [DEPTH];
  logic [31:0]       fifo_d [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              mem_wr_en_q, mem_wr_en_d;
  logic [31:0]       mem_wr_data_q, mem_wr_data_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              illegal_q, illegal_d;

  logic [31:0] enc_word;
  logic        enc_legal;
  logic        accept;
  logic        push;
  logic        pop;

  // Start blocks acceptance so a request never lands in a FIFO being flushed.
  assign req.req_ready = (count_q != c_full) && !start;
  assign accept        = req.req_valid && req.req_ready;
  assign push          = accept && enc_legal;
  assign pop           = mem_wr_en_q && mem_wr_ready;

  assign mem_wr_en   = mem_wr_en_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wr_data = mem_wr_data_q;
  assign count       = count_q;
  assign illegal     = illegal_q;

  // Pack the request fields into the RV32I format selected by its class.
  always_comb begin
    enc_word  = '0;
    enc_legal = 1'b1;
    case (req.req_class)
      c_cls_op: enc_word = {req.req_funct7, req.req_rs2, req.req_rs1,
                            req.req_funct3, req.req_rd, req.req_class, 2'b11};
      c_cls_load, c_cls_fence, c_cls_op_imm, c_cls_jalr:
        enc_word = {req.req_imm[11:0], req.req_rs1, req.req_funct3,
                    req.req_rd, req.req_class, 2'b11};
      c_cls_store:
        enc_word = {req.req_imm[11:5], req.req_rs2, req.req_rs1, req.req_funct3,
                    req.req_imm[4:0], req.req_class, 2'b11};
      c_cls_branch:
        enc_word = {req.req_imm[12], req.req_imm[10:5], req.req_rs2, req.req_rs1,
                    req.req_funct3, req.req_imm[4:1], req.req_imm[11],
                    req.req_class, 2'b11};
      c_cls_auipc, c_cls_lui:
        enc_word = {req.req_imm[31:12], req.req_rd, req.req_class, 2'b11};
      c_cls_jal:
        enc_word = {req.req_imm[20], req.req_imm[10:1], req.req_imm[11],
                    req.req_imm[19:12], req.req_rd, req.req_class, 2'b11};
      default: enc_legal = 1'b0;
    endcase
  end

  // FIFO push/pop, write-port address and the registered head word. The head
  // is taken from the next-state array so a push into an empty FIFO appears
  // on the write port one cycle after acceptance.
  always_comb begin
    fifo_d        = fifo_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    mem_addr_d    = mem_addr_q;
    illegal_d     = illegal_q;
    mem_wr_data_d = mem_wr_data_q;
    mem_wr_en_d   = mem_wr_en_q;

    if (start) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      mem_addr_d  = base_addr;
      illegal_d   = 1'b0;
      mem_wr_en_d = 1'b0;
    end else begin
      if (push) begin
        fifo_d[wr_ptr_q] = enc_word;
        wr_ptr_d         = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d   = rd_ptr_q + PTR_W'(1);
        mem_addr_d = mem_addr_q + ADDR_W'(4);
      end
      if (accept && !enc_legal) begin
        illegal_d = 1'b1;
      end
      count_d     = count_q + CNT_W'(push) - CNT_W'(pop);
      mem_wr_en_d = (count_d != '0);
      if (count_d != '0) begin
        mem_wr_data_d = fifo_d[rd_ptr_d];
      end
    end
  end

  // State registers; asynchronous reset returns every output to idle at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        fifo_q[i] <= '0;
      end
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      mem_addr_q    <= '0;
      illegal_q     <= 1'b0;
      mem_wr_data_q <= '0;
      mem_wr_en_q   <= 1'b0;
    end else begin
      fifo_q        <= fifo_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      mem_addr_q    <= mem_addr_d;
      illegal_q     <= illegal_d;
      mem_wr_data_q <= mem_wr_data_d;
      mem_wr_en_q   <= mem_wr_en_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_instr_encoder_writer.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_encoder_writer
// Description : Self-checking bench for instr_encoder_writer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_encoder_writer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] base_addr;
  logic        mem_wr_en;
  logic [31:0] mem_addr;
  logic [31:0] mem_wr_data;
  logic        mem_wr_ready;
  logic [2:0]  count;
  logic        illegal;

  instr_encoder_writer_if req_if ();

  instr_encoder_writer #(.DEPTH(4), .ADDR_W(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .base_addr    (base_addr),
    .req          (req_if),
    .mem_wr_en    (mem_wr_en),
    .mem_addr     (mem_addr),
    .mem_wr_data  (mem_wr_data),
    .mem_wr_ready (mem_wr_ready),
    .count        (count),
    .illegal      (illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  cls;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
    logic [31:0] exp;
  } vec_t;

  int total = 0;
  int bad   = 0;

  // Writes seen by memory, captured at each completing edge
  logic [31:0] cap_addr [$];
  logic [31:0] cap_data [$];

  // Record every write the IMEM side would commit
  always @(posedge clk) begin
    if (rst_n && mem_wr_en && mem_wr_ready) begin
      cap_addr.push_back(mem_addr);
      cap_data.push_back(mem_wr_data);
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input vec_t v);
    req_if.req_valid  = 1'b1;
    req_if.req_class  = v.cls;
    req_if.req_rd     = v.rd;
    req_if.req_rs1    = v.rs1;
    req_if.req_rs2    = v.rs2;
    req_if.req_funct3 = v.f3;
    req_if.req_funct7 = v.f7;
    req_if.req_imm    = v.imm;
    #1;
  endtask

  function automatic vec_t addi_vec(input int k);
    vec_t v;
    v.cls = 5'h04; v.rd = 5'(k); v.rs1 = 5'd0; v.rs2 = 5'd0;
    v.f3 = 3'd0; v.f7 = 7'd0; v.imm = 32'(k);
    v.exp = (32'(k) << 20) | (32'(k) << 7) | 32'h13;
    return v;
  endfunction

  vec_t        tab [11];
  vec_t        v;
  logic [31:0] nxt_addr;
  logic [31:0] full_w [5];
  logic [31:0] full_a0;
  int          k5;
  int          ncap;
  logic        acc;

  initial begin
    //         cls    rd     rs1    rs2    f3    f7      imm           expected
    tab[0]  = '{5'h04, 5'd5,  5'd6,  5'd0,  3'd0, 7'h00, 32'hFFFFFFFF, 32'hFFF30293}; // addi x5,x6,-1
    tab[1]  = '{5'h0D, 5'd1,  5'd31, 5'd31, 3'd7, 7'h7F, 32'h12345ABC, 32'h123450B7}; // lui, junk fields
    tab[2]  = '{5'h1B, 5'd1,  5'd5,  5'd0,  3'd0, 7'h00, 32'h00000009, 32'h008000EF}; // jal +8, imm[0] junk
    tab[3]  = '{5'h08, 5'd31, 5'd3,  5'd2,  3'd2, 7'h7F, 32'h00000004, 32'h0021A223}; // sw x2,4(x3)
    tab[4]  = '{5'h18, 5'd0,  5'd0,  5'd0,  3'd0, 7'h00, 32'hFFFFFFFC, 32'hFE000EE3}; // beq -4
    tab[5]  = '{5'h0C, 5'd3,  5'd1,  5'd2,  3'd0, 7'h20, 32'hFFFFFFFF, 32'h402081B3}; // sub x3,x1,x2
    tab[6]  = '{5'h00, 5'd7,  5'd8,  5'd9,  3'd2, 7'h00, 32'hFFFFFFF8, 32'hFF842383}; // lw x7,-8(x8)
    tab[7]  = '{5'h05, 5'd10, 5'd0,  5'd0,  3'd0, 7'h00, 32'hFFFFF000, 32'hFFFFF517}; // auipc
    tab[8]  = '{5'h19, 5'd0,  5'd1,  5'd3,  3'd0, 7'h00, 32'h00000000, 32'h00008067}; // jalr x0,0(x1)
    tab[9]  = '{5'h03, 5'd0,  5'd0,  5'd0,  3'd0, 7'h00, 32'h000000FF, 32'h0FF0000F}; // fence
    tab[10] = '{5'h1B, 5'd0,  5'd0,  5'd0,  3'd0, 7'h00, 32'hFFFFF800, 32'h801FF06F}; // jal x0,-2048

    rst_n = 1'b0; start = 1'b0; base_addr = '0; mem_wr_ready = 1'b1;
    req_if.req_valid = 1'b0; req_if.req_class = '0; req_if.req_rd = '0;
    req_if.req_rs1 = '0; req_if.req_rs2 = '0; req_if.req_funct3 = '0;
    req_if.req_funct7 = '0; req_if.req_imm = '0;
    tick(); tick();
    chk("rst_en",    32'(mem_wr_en), 32'd0);
    chk("rst_addr",  mem_addr, 32'd0);
    chk("rst_data",  mem_wr_data, 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_ill",   32'(illegal), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("rst_ready", 32'(req_if.req_ready), 32'd1);

    // Start at 0x100
    base_addr = 32'h100; start = 1'b1; tick(); start = 1'b0;
    chk("start_addr", mem_addr, 32'h100);
    nxt_addr = 32'h100;

    // Table: one request at a time, first-word latency and encoding
    for (int i = 0; i < 11; i++) begin
      drive(tab[i]);
      chk($sformatf("v%0d_ready", i), 32'(req_if.req_ready), 32'd1);
      tick();
      req_if.req_valid = 1'b0;
      chk($sformatf("v%0d_en", i),    32'(mem_wr_en), 32'd1);
      chk($sformatf("v%0d_data", i),  mem_wr_data, tab[i].exp);
      chk($sformatf("v%0d_addr", i),  mem_addr, nxt_addr);
      chk($sformatf("v%0d_cnt", i),   32'(count), 32'd1);
      tick();
      nxt_addr = nxt_addr + 32'd4;
      chk($sformatf("v%0d_drain", i), 32'(count), 32'd0);
    end

    // Back-to-back lui then jal: push and pop on the same edge
    drive(tab[1]);
    tick();
    chk("b2b_lui_data", mem_wr_data, 32'h123450B7);
    chk("b2b_lui_addr", mem_addr, nxt_addr);
    drive(tab[2]);
    tick();
    req_if.req_valid = 1'b0;
    chk("b2b_jal_data", mem_wr_data, 32'h008000EF);
    chk("b2b_jal_addr", mem_addr, nxt_addr + 32'd4);
    chk("b2b_cnt",      32'(count), 32'd1);
    tick();
    chk("b2b_empty_en", 32'(mem_wr_en), 32'd0);
    nxt_addr = nxt_addr + 32'd8;

    // Full FIFO with memory stalled, then release
    mem_wr_ready = 1'b0;
    cap_addr.delete(); cap_data.delete();
    full_a0 = nxt_addr;
    for (int i = 0; i < 5; i++) full_w[i] = addi_vec(i + 1).exp;
    for (int i = 0; i < 4; i++) begin
      drive(addi_vec(i + 1));
      tick();
    end
    drive(addi_vec(5));
    chk("full_ready", 32'(req_if.req_ready), 32'd0);
    chk("full_cnt",   32'(count), 32'd4);
    chk("full_data",  mem_wr_data, full_w[0]);
    tick(); tick();
    chk("full_stable_data", mem_wr_data, full_w[0]);
    chk("full_stable_cnt",  32'(count), 32'd4);
    chk("full_stable_addr", mem_addr, full_a0);
    mem_wr_ready = 1'b1;
    k5 = 0;
    while ((count != 0 || req_if.req_valid) && k5 < 20) begin
      acc = req_if.req_valid && req_if.req_ready;
      tick();
      if (acc) req_if.req_valid = 1'b0;
      k5++;
    end
    chk("full_drain_timeout", 32'(k5 < 20), 32'd1);
    chk("full_nwrites", 32'(cap_data.size()), 32'd5);
    for (int i = 0; i < 5; i++) begin
      if (i < cap_data.size()) begin
        chk($sformatf("full_w%0d_data", i), cap_data[i], full_w[i]);
        chk($sformatf("full_w%0d_addr", i), cap_addr[i], full_a0 + 32'(4 * i));
      end
    end

    // Illegal class: consumed, nothing written, sticky flag
    ncap = cap_data.size();
    v = addi_vec(1); v.cls = 5'h1F;
    drive(v);
    chk("ill_ready", 32'(req_if.req_ready), 32'd1);
    tick();
    req_if.req_valid = 1'b0;
    chk("ill_flag", 32'(illegal), 32'd1);
    chk("ill_cnt",  32'(count), 32'd0);
    chk("ill_en",   32'(mem_wr_en), 32'd0);
    tick(); tick();
    chk("ill_sticky", 32'(illegal), 32'd1);
    chk("ill_nowrite", 32'(cap_data.size()), 32'(ncap));
    base_addr = 32'h200; start = 1'b1; tick(); start = 1'b0;
    chk("ill_clr",      32'(illegal), 32'd0);
    chk("ill_clr_addr", mem_addr, 32'h200);
    chk("ill_clr_cnt",  32'(count), 32'd0);

    // Start with two queued words and a pending request
    mem_wr_ready = 1'b0;
    drive(addi_vec(1)); tick();
    drive(addi_vec(2)); tick();
    chk("st_cnt2", 32'(count), 32'd2);
    drive(addi_vec(3));
    base_addr = 32'h300; start = 1'b1;
    #1;
    chk("st_ready", 32'(req_if.req_ready), 32'd0);
    tick();
    start = 1'b0; req_if.req_valid = 1'b0;
    chk("st_cnt0", 32'(count), 32'd0);
    chk("st_en",   32'(mem_wr_en), 32'd0);
    chk("st_addr", mem_addr, 32'h300);
    ncap = cap_data.size();
    mem_wr_ready = 1'b1;
    tick(); tick(); tick();
    chk("st_nowrite", 32'(cap_data.size()), 32'(ncap));

    // Asynchronous reset in the middle of a stalled write
    mem_wr_ready = 1'b0;
    drive(addi_vec(4)); tick();
    req_if.req_valid = 1'b0;
    chk("ar_en_before", 32'(mem_wr_en), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("ar_en",   32'(mem_wr_en), 32'd0);
    chk("ar_cnt",  32'(count), 32'd0);
    chk("ar_addr", mem_addr, 32'd0);
    chk("ar_data", mem_wr_data, 32'd0);
    mem_wr_ready = 1'b1;
    tick();
    rst_n = 1'b1;
    #1;
    chk("ar_ready", 32'(req_if.req_ready), 32'd1);
    chk("ar_nowrite", 32'(cap_data.size()), 32'(ncap));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
